// File: rtl/pong_pkg.sv
// Shared pong constants: screen, ball and paddle geometry,
// referee FSM states and winner codes.
package pong_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BALL_SIZE   = 10;
  localparam int PADDLE_W    = 8;
  localparam int PADDLE_H    = 64;
  localparam int PADDLE_L_X  = 16;
  localparam int PADDLE_R_X  = 616;
  localparam int WIN_SCORE   = 7;
  localparam int SERVE_DELAY = 60;

  localparam int CNT_W = $clog2(SERVE_DELAY);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_WAIT,
    PLAY,
    POINT,
    GAME_OVER
  } ref_state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/pong_paddle_hit.sv
// Combinational ball/paddle overlap test for one paddle.
// All sums are 11 bits wide so edge arithmetic never wraps.
module pong_paddle_hit
  import pong_pkg::*;
#(
  parameter int PADDLE_X = PADDLE_L_X
) (
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_y,
  output logic       hit
);

  localparam logic [10:0] X_LO = 11'(PADDLE_X);
  localparam logic [10:0] X_HI = 11'(PADDLE_X + PADDLE_W);
  localparam logic [10:0] BS   = 11'(BALL_SIZE);
  localparam logic [10:0] PH   = 11'(PADDLE_H);

  logic [10:0] bx;
  logic [10:0] by;
  logic [10:0] py;

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign py = {1'b0, paddle_y};

  assign hit = (bx < X_HI)
            && (bx + BS > X_LO)
            && (by + BS > py)
            && (by < py + PH);

endmodule

// File: rtl/pong_referee.sv
// Pong referee: paddle hits, misses, scoring and serve timing.
// Optional PONG_SPEEDUP_EN adds a per-rally hit counter.
module pong_referee
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       ball_left,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  input  logic       start,
  output logic       bounce_x,
  output logic       serve,
  output logic       serve_left,
  output logic       play_en,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [1:0] speed_level
);

  localparam logic [9:0] MISS_R = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [3:0] WIN    = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  ref_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic cool, cool_n;
  logic left_pt, left_pt_n;
  logic bounce_n, serve_n, serve_left_n, play_n;
  logic [3:0] score_l_n, score_r_n;
  logic [1:0] winner_n;

  logic hit_l, hit_r, hit, miss_l, miss_r;

  pong_paddle_hit #(.PADDLE_X(PADDLE_L_X)) u_hit_l (
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .paddle_y (paddle_l_y),
    .hit      (hit_l)
  );

  pong_paddle_hit #(.PADDLE_X(PADDLE_R_X)) u_hit_r (
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .paddle_y (paddle_r_y),
    .hit      (hit_r)
  );

  assign hit    = !cool && (ball_left ? hit_l : hit_r);
  assign miss_l = ball_left && (ball_x == 10'd0);
  assign miss_r = !ball_left && (ball_x >= MISS_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cool       <= 1'b0;
      left_pt    <= 1'b0;
      bounce_x   <= 1'b0;
      serve      <= 1'b0;
      serve_left <= 1'b0;
      play_en    <= 1'b0;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      winner     <= WIN_NONE;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cool       <= cool_n;
      left_pt    <= left_pt_n;
      bounce_x   <= bounce_n;
      serve      <= serve_n;
      serve_left <= serve_left_n;
      play_en    <= play_n;
      score_l    <= score_l_n;
      score_r    <= score_r_n;
      winner     <= winner_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cool_n       = cool;
    left_pt_n    = left_pt;
    bounce_n     = 1'b0;
    serve_n      = 1'b0;
    serve_left_n = serve_left;
    score_l_n    = score_l;
    score_r_n    = score_r;
    winner_n     = winner;
    // cooldown only masks hits for the tick right after a bounce
    if (tick) cool_n = 1'b0;
    unique case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_n      = SERVE_WAIT;
          cnt_n        = '0;
          serve_left_n = 1'b0;
          score_l_n    = 4'd0;
          score_r_n    = 4'd0;
          winner_n     = WIN_NONE;
        end
      end
      SERVE_WAIT: begin
        if (tick) begin
          if (cnt == CNT_LAST) begin
            serve_n = 1'b1;
            state_n = PLAY;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (hit) begin
            bounce_n = 1'b1;
            cool_n   = 1'b1;
          end else if (miss_l) begin
            left_pt_n    = 1'b0;
            serve_left_n = 1'b1;
            state_n      = POINT;
          end else if (miss_r) begin
            left_pt_n    = 1'b1;
            serve_left_n = 1'b0;
            state_n      = POINT;
          end
        end
      end
      POINT: begin
        cnt_n   = '0;
        state_n = SERVE_WAIT;
        if (left_pt) begin
          if (score_l != WIN) score_l_n = score_l + 4'd1;
          if (score_l_n == WIN) begin
            winner_n = WIN_LEFT;
            state_n  = GAME_OVER;
          end
        end else begin
          if (score_r != WIN) score_r_n = score_r + 4'd1;
          if (score_r_n == WIN) begin
            winner_n = WIN_RIGHT;
            state_n  = GAME_OVER;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    play_n = (state_n == PLAY);
  end

`ifdef PONG_SPEEDUP_EN
  logic [3:0] hits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits <= 4'd0;
    end else if (serve_n) begin
      hits <= 4'd0;
    end else if (bounce_n && hits != 4'd12) begin
      hits <= hits + 4'd1;
    end
  end

  assign speed_level = (hits >= 4'd12) ? 2'd3 : hits[3:2];
`else
  assign speed_level = 2'd0;
`endif

endmodule
